// File: rtl/board_game_pkg.sv
// ============================================================================
// Module      : board_game_pkg
// Description : Shared state encoding, cell encoding and width helpers for the
//               board game controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package board_game_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_INIT  = 3'd0;
  localparam state_t ST_IDLE  = 3'd1;
  localparam state_t ST_SEEK  = 3'd2;
  localparam state_t ST_PLACE = 3'd3;
  localparam state_t ST_CHECK = 3'd4;
  localparam state_t ST_OVER  = 3'd5;
  localparam state_t ST_NEXT  = 3'd6;

  localparam int EMPTY = 0;

  function automatic int cw_f(input int n);
    return $clog2(n * n);
  endfunction

  function automatic int pw_f(input int p);
    return $clog2(p + 1);
  endfunction

  function automatic int plw_f(input int p);
    return $clog2(p);
  endfunction

  function automatic int lw_f(input int n);
    return $clog2(2 * n + 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/board_line_check.sv
// ============================================================================
// Module      : board_line_check
// Description : Combinational test of one board line (row, column or diagonal)
//               against a player code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module board_line_check
  import board_game_pkg::*;
#(
  parameter int BOARD_N     = 3,
  parameter int NUM_PLAYERS = 2
) (
  input  logic [BOARD_N*BOARD_N*pw_f(NUM_PLAYERS)-1:0] board,
  input  logic [lw_f(BOARD_N)-1:0]                     line_idx,
  input  logic [pw_f(NUM_PLAYERS)-1:0]                 code,
  output logic                                         complete
);

  localparam int c_pw = pw_f(NUM_PLAYERS);

  int w_line;
  int w_cell;

  assign w_line = int'(line_idx);

  // Lines 0..N-1 are rows, N..2N-1 columns, 2N main diagonal, 2N+1 anti-diagonal.
  always_comb begin
    complete = 1'b1;
    w_cell   = 0;
    for (int k = 0; k < BOARD_N; k++) begin
      if (w_line < BOARD_N)
        w_cell = w_line * BOARD_N + k;
      else if (w_line < 2 * BOARD_N)
        w_cell = k * BOARD_N + (w_line - BOARD_N);
      else if (w_line == 2 * BOARD_N)
        w_cell = k * BOARD_N + k;
      else
        w_cell = k * BOARD_N + (BOARD_N - 1 - k);
      if (board[w_cell*c_pw +: c_pw] != code)
        complete = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/board_game_ctrl.sv
// ============================================================================
// Module      : board_game_ctrl
// Description : N-in-a-row board game controller with cursor seek, line
//               checking over several cycles and saturating per-player scores.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module board_game_ctrl
  import board_game_pkg::*;
#(
  parameter int BOARD_N     = 3,
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              move,
  input  logic                              sel,
  input  logic                              clear_score,
  input  logic [cw_f(BOARD_N)-1:0]          rd_addr,
  output logic [pw_f(NUM_PLAYERS)-1:0]      rd_data,
  output logic [cw_f(BOARD_N)-1:0]          cursor,
  output logic [plw_f(NUM_PLAYERS)-1:0]     player,
  output logic                              busy,
  output logic                              win,
  output logic                              tie,
  output logic [plw_f(NUM_PLAYERS)-1:0]     winner,
  output logic [NUM_PLAYERS*SCORE_W-1:0]    score
);

  localparam int c_cw    = cw_f(BOARD_N);
  localparam int c_pw    = pw_f(NUM_PLAYERS);
  localparam int c_plw   = plw_f(NUM_PLAYERS);
  localparam int c_lw    = lw_f(BOARD_N);
  localparam int c_cells = BOARD_N * BOARD_N;

  localparam logic [c_pw-1:0]  c_empty       = c_pw'(EMPTY);
  localparam logic [c_cw-1:0]  c_last_cell   = c_cw'(c_cells - 1);
  localparam logic [c_lw-1:0]  c_last_line   = c_lw'(2 * BOARD_N + 1);
  localparam logic [c_plw-1:0] c_last_player = c_plw'(NUM_PLAYERS - 1);

  state_t                     r_state;
  logic [c_cells*c_pw-1:0]    r_board;
  logic [c_cw-1:0]            r_cursor;
  logic [c_cw-1:0]            r_seek_cnt;
  logic [c_plw-1:0]           r_player;
  logic [c_plw-1:0]           r_winner;
  logic [c_lw-1:0]            r_line;
  logic                       r_win;
  logic                       r_tie;
  logic [SCORE_W-1:0]         r_score [NUM_PLAYERS];

  logic [c_cw-1:0]            w_cursor_inc;
  logic [c_plw-1:0]           w_player_inc;
  logic [c_pw-1:0]            w_code;
  logic [c_pw-1:0]            w_cur_cell;
  logic                       w_inc_empty;
  logic                       w_full;
  logic                       w_line_done;

  assign w_cursor_inc = (r_cursor == c_last_cell) ? '0 : r_cursor + 1'b1;
  assign w_player_inc = (r_player == c_last_player) ? '0 : r_player + 1'b1;
  assign w_code       = c_pw'(r_player) + c_pw'(1);
  assign w_cur_cell   = r_board[int'(r_cursor)*c_pw +: c_pw];
  assign w_inc_empty  = (r_board[int'(w_cursor_inc)*c_pw +: c_pw] == c_empty);

  always_comb begin
    w_full = 1'b1;
    for (int i = 0; i < c_cells; i++)
      if (r_board[i*c_pw +: c_pw] == c_empty)
        w_full = 1'b0;
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < c_cells)
      rd_data = r_board[int'(rd_addr)*c_pw +: c_pw];
  end

  board_line_check #(
    .BOARD_N     (BOARD_N),
    .NUM_PLAYERS (NUM_PLAYERS)
  ) u_line_check (
    .board    (r_board),
    .line_idx (r_line),
    .code     (w_code),
    .complete (w_line_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_INIT;
      r_board    <= '0;
      r_cursor   <= '0;
      r_seek_cnt <= '0;
      r_player   <= '0;
      r_winner   <= '0;
      r_line     <= '0;
      r_win      <= 1'b0;
      r_tie      <= 1'b0;
    end else begin
      r_win <= 1'b0;
      r_tie <= 1'b0;
      case (r_state)
        ST_INIT: begin
          r_board  <= '0;
          r_cursor <= '0;
          r_player <= '0;
          r_state  <= ST_IDLE;
        end
        ST_IDLE: begin
          if (move && !sel) begin
            r_seek_cnt <= '0;
            r_state    <= ST_SEEK;
          end else if (sel && !move) begin
            r_state <= ST_PLACE;
          end
        end
        ST_SEEK: begin
          // Bounded walk: a full lap of the board always ends the search.
          r_cursor   <= w_cursor_inc;
          r_seek_cnt <= r_seek_cnt + 1'b1;
          if (w_inc_empty || r_seek_cnt == c_last_cell)
            r_state <= ST_IDLE;
        end
        ST_PLACE: begin
          if (w_cur_cell != c_empty) begin
            r_state <= ST_IDLE;
          end else begin
            r_board[int'(r_cursor)*c_pw +: c_pw] <= w_code;
            r_line  <= '0;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_line_done) begin
            r_win    <= 1'b1;
            r_winner <= r_player;
            r_state  <= ST_OVER;
          end else if (r_line == c_last_line) begin
            r_tie   <= w_full;
            r_state <= w_full ? ST_OVER : ST_NEXT;
          end else begin
            r_line <= r_line + 1'b1;
          end
        end
        ST_OVER: begin
          r_board <= '0;
          r_state <= ST_NEXT;
        end
        ST_NEXT: begin
          r_player <= w_player_inc;
          r_cursor <= '0;
          if (r_board[c_pw-1:0] != c_empty) begin
            r_seek_cnt <= '0;
            r_state    <= ST_SEEK;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  // r_win is high exactly during the OVER cycle that follows a win.
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_score
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)
        r_score[p] <= '0;
      else if (clear_score)
        r_score[p] <= '0;
      else if (r_state == ST_OVER && r_win && int'(r_winner) == p && r_score[p] != '1)
        r_score[p] <= r_score[p] + 1'b1;
    end
    assign score[p*SCORE_W +: SCORE_W] = r_score[p];
  end

  assign cursor = r_cursor;
  assign player = r_player;
  assign winner = r_winner;
  assign win    = r_win;
  assign tie    = r_tie;
  assign busy   = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_board_game_ctrl.sv
// ============================================================================
// Module      : tb_board_game_ctrl
// Description : Scoreboard bench for board_game_ctrl (N=3, two players, 2-bit
//               scores) with a game-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_board_game_ctrl;

  localparam int N = 3, P = 2, SW = 2, CELLS = 9, CW = 4, PW = 2, PLW = 1;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0, reset = 1'b1, move = 1'b0, sel = 1'b0, clear_score = 1'b0;
  logic [CW-1:0]   rd_addr = '0;
  logic [PW-1:0]   rd_data;
  logic [CW-1:0]   cursor;
  logic [PLW-1:0]  player, winner;
  logic            busy, win, tie;
  logic [P*SW-1:0] score;

  board_game_ctrl #(.BOARD_N(N), .NUM_PLAYERS(P), .SCORE_W(SW)) dut (
    .clk(clk), .reset(reset), .move(move), .sel(sel), .clear_score(clear_score),
    .rd_addr(rd_addr), .rd_data(rd_data), .cursor(cursor), .player(player),
    .busy(busy), .win(win), .tie(tie), .winner(winner), .score(score)
  );

  always #20 clk = ~clk;

  typedef struct packed {
    logic [CELLS*PW-1:0] board;
    logic [CW-1:0]       cursor;
    logic [PLW-1:0]      player;
    logic [PLW-1:0]      winner;
    logic [P*SW-1:0]     score;
  } snap_t;

  typedef struct packed {
    logic           is_win;
    logic [PLW-1:0] who;
  } evt_t;

  snap_t snap_q[$];
  evt_t  evt_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  // Game-level reference model
  int m_board[CELLS];
  int m_cursor, m_player, m_winner;
  int m_score[P];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic bit m_line(input int code);
    bit all;
    for (int r = 0; r < N; r++) begin
      all = 1'b1;
      for (int c = 0; c < N; c++) if (m_board[r*N+c] != code) all = 1'b0;
      if (all) return 1'b1;
    end
    for (int c = 0; c < N; c++) begin
      all = 1'b1;
      for (int r = 0; r < N; r++) if (m_board[r*N+c] != code) all = 1'b0;
      if (all) return 1'b1;
    end
    all = 1'b1;
    for (int k = 0; k < N; k++) if (m_board[k*N+k] != code) all = 1'b0;
    if (all) return 1'b1;
    all = 1'b1;
    for (int k = 0; k < N; k++) if (m_board[k*N+(N-1-k)] != code) all = 1'b0;
    return all;
  endfunction

  function automatic int m_next_empty(input int from);
    for (int s = 1; s <= CELLS; s++)
      if (m_board[(from + s) % CELLS] == 0) return (from + s) % CELLS;
    return from;
  endfunction

  task automatic push_snap();
    snap_t s;
    for (int i = 0; i < CELLS; i++) s.board[i*PW +: PW] = PW'(m_board[i]);
    for (int p = 0; p < P; p++) s.score[p*SW +: SW] = SW'(m_score[p]);
    s.cursor = CW'(m_cursor);
    s.player = PLW'(m_player);
    s.winner = PLW'(m_winner);
    snap_q.push_back(s);
  endtask

  task automatic m_reset();
    for (int i = 0; i < CELLS; i++) m_board[i] = 0;
    for (int p = 0; p < P; p++) m_score[p] = 0;
    m_cursor = 0; m_player = 0; m_winner = 0;
  endtask

  task automatic m_move();
    m_cursor = m_next_empty(m_cursor);
    push_snap();
  endtask

  task automatic m_sel(input bit clr_on_win);
    bit full;
    evt_t e;
    if (m_board[m_cursor] != 0) begin
      push_snap();
      return;
    end
    m_board[m_cursor] = m_player + 1;
    full = 1'b1;
    for (int i = 0; i < CELLS; i++) if (m_board[i] == 0) full = 1'b0;
    if (m_line(m_player + 1)) begin
      e.is_win = 1'b1; e.who = PLW'(m_player);
      evt_q.push_back(e);
      m_winner = m_player;
      if (m_score[m_player] < SMAX) m_score[m_player]++;
      if (clr_on_win) for (int p = 0; p < P; p++) m_score[p] = 0;
      for (int i = 0; i < CELLS; i++) m_board[i] = 0;
    end else if (full) begin
      e.is_win = 1'b0; e.who = '0;
      evt_q.push_back(e);
      for (int i = 0; i < CELLS; i++) m_board[i] = 0;
    end
    m_player = (m_player + 1) % P;
    m_cursor = (m_board[0] != 0) ? m_next_empty(0) : 0;
    push_snap();
  endtask

  // Waits for the controller to return to IDLE; optionally lands clear_score on the win's score edge.
  task automatic wait_not_busy(input string name, input bit clr_on_win);
    int cyc;
    cyc = 0;
    @(negedge clk);
    move = 1'b0;
    sel  = 1'b0;
    while (busy && cyc < 64) begin
      clear_score = clr_on_win && win;
      @(negedge clk);
      cyc++;
    end
    clear_score = 1'b0;
    if (busy) begin
      n_checks++;
      $display("FAIL %s: busy=1 after 64 cycles, required 0", name);
    end
  endtask

  task automatic do_cmd(input bit mv, input bit sl, input bit clr_on_win);
    move = mv;
    sel  = sl;
    wait_not_busy(mv ? "move_done" : "sel_done", clr_on_win);
  endtask

  task automatic goto(input int target);
    int guard;
    guard = 0;
    while (m_cursor != target && guard < CELLS) begin
      m_move();
      do_cmd(1'b1, 1'b0, 1'b0);
      guard++;
    end
  endtask

  task automatic place(input int target, input bit clr_on_win);
    goto(target);
    m_sel(clr_on_win);
    do_cmd(1'b0, 1'b1, clr_on_win);
  endtask

  // mode 0: normal win, 1: clear_score on the scoring edge, 2: reset during CHECK
  task automatic win_for(input int p, input int mode);
    int seq[6];
    int n;
    if (m_player == p) begin seq = '{0, 3, 1, 4, 2, 0}; n = 5; end
    else               begin seq = '{3, 0, 4, 1, 6, 2}; n = 6; end
    for (int i = 0; i < n - 1; i++) place(seq[i], 1'b0);
    if (mode != 2) begin
      place(seq[n-1], mode == 1);
    end else begin
      goto(seq[n-1]);
      sel = 1'b1;
      @(negedge clk);
      sel = 1'b0;
      @(negedge clk);
      #12 reset = 1'b0;
      #1;
      check("abort_cursor", cursor, 0);
      check("abort_player", player, 0);
      check("abort_winner", winner, 0);
      check("abort_score", score, 0);
      check("abort_win", win, 0);
      check("abort_tie", tie, 0);
      m_reset();
      repeat (2) @(negedge clk);
      check("abort_no_win", win, 0);
      push_snap();
      reset = 1'b1;
      wait_not_busy("abort_release", 1'b0);
    end
  endtask

  // Monitor: pops the scoreboard on win/tie pulses and whenever busy falls.
  initial begin
    bit    prev_busy;
    evt_t  e;
    snap_t s;
    logic [CELLS*PW-1:0] act_board;
    prev_busy = 1'b1;
    forever begin
      @(negedge clk);
      if (win || tie) begin
        if (evt_q.size() == 0) begin
          n_checks++;
          $display("FAIL evt_unexpected: win=%0b tie=%0b, required no pulse", win, tie);
        end else begin
          e = evt_q.pop_front();
          check("evt_kind", {win, tie}, e.is_win ? 2'b10 : 2'b01);
          if (e.is_win) check("evt_winner", winner, e.who);
        end
      end
      if (prev_busy && !busy) begin
        if (snap_q.size() == 0) begin
          n_checks++;
          $display("FAIL snap_unexpected: busy fell with cursor=%0d, required no idle return", cursor);
        end else begin
          s = snap_q.pop_front();
          check("cursor", cursor, s.cursor);
          check("player", player, s.player);
          check("winner", winner, s.winner);
          check("score", score, s.score);
          for (int i = 0; i < CELLS; i++) begin
            rd_addr = CW'(i);
            #1;
            act_board[i*PW +: PW] = rd_data;
          end
          check("board", act_board, s.board);
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    int r;
    m_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_cursor", cursor, 0);
    check("rst_player", player, 0);
    check("rst_winner", winner, 0);
    check("rst_score", score, 0);
    check("rst_win", win, 0);
    check("rst_tie", tie, 0);
    check("rst_busy", busy, 1);
    repeat (2) @(negedge clk);
    push_snap();
    reset = 1'b1;
    wait_not_busy("reset_release", 1'b0);

    // First mark, then player 0 completes row 0 against player 1 on cells 3,4
    place(0, 1'b0);
    place(3, 1'b0);
    place(1, 1'b0);
    place(4, 1'b0);
    place(2, 1'b0);

    // Tie pattern X O X / X O O / O X X with X = player to move
    place(0, 1'b0); place(1, 1'b0); place(2, 1'b0);
    place(4, 1'b0); place(3, 1'b0); place(5, 1'b0);
    place(7, 1'b0); place(6, 1'b0); place(8, 1'b0);

    // move and sel together are ignored
    move = 1'b1; sel = 1'b1;
    @(negedge clk);
    move = 1'b0; sel = 1'b0;
    check("both_busy", busy, 0);
    check("both_cursor", cursor, CW'(m_cursor));

    // Saturation at 3, then clear_score
    repeat (3) win_for(0, 0);
    clear_score = 1'b1;
    @(negedge clk);
    clear_score = 1'b0;
    for (int p = 0; p < P; p++) m_score[p] = 0;
    check("score_cleared", score, 0);

    win_for(1, 0);
    win_for(0, 1);
    win_for(1, 0);
    win_for(0, 2);

    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 99);
      if (r < 45) begin
        m_move();
        do_cmd(1'b1, 1'b0, 1'b0);
      end else if (r < 85) begin
        m_sel(1'b0);
        do_cmd(1'b0, 1'b1, 1'b0);
      end else if (r < 90) begin
        move = 1'b1; sel = 1'b1;
        @(negedge clk);
        move = 1'b0; sel = 1'b0;
        check("rand_both_busy", busy, 0);
      end else if (r < 95) begin
        clear_score = 1'b1;
        @(negedge clk);
        clear_score = 1'b0;
        for (int p = 0; p < P; p++) m_score[p] = 0;
      end else begin
        @(negedge clk);
      end
    end

    m_move();
    do_cmd(1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("snap_q_drained", snap_q.size(), 0);
    check("evt_q_drained", evt_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
